// File: rtl/ex_stage.sv
// EX pipeline stage: operand select, ALU, and the EX/MEM pipeline register.
// Optional EX-to-EX forwarding is compiled in when EX_STAGE_FORWARD_EN is defined.
module ex_stage #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [2:0]        ALU_control,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] imm,
    input  logic              alu_src,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    input  logic [4:0]        rd_addr,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_alu_result,
    output logic              ex_zero,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [4:0]        ex_rd_addr,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write
);

    localparam int unsigned REG_W = 5;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic              r_valid;
    logic [DATA_W-1:0] r_alu_result;
    logic              r_zero;
    logic [DATA_W-1:0] r_store_data;
    logic [REG_W-1:0]  r_rd_addr;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;

    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_rt_val;
    logic [DATA_W-1:0] w_op_b;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_zero;
    logic              w_slt;

`ifdef EX_STAGE_FORWARD_EN
    // A load in EX/MEM has no result yet, so it is never a forwarding source.
    logic w_fwd_src_ok;
    logic w_fwd_rs;
    logic w_fwd_rt;

    assign w_fwd_src_ok = r_valid && r_reg_write && !r_mem_read && (r_rd_addr != REG_W'(0));
    assign w_fwd_rs     = w_fwd_src_ok && (r_rd_addr == rs_addr);
    assign w_fwd_rt     = w_fwd_src_ok && (r_rd_addr == rt_addr);

    assign w_op_a   = w_fwd_rs ? r_alu_result : rs_data;
    assign w_rt_val = w_fwd_rt ? r_alu_result : rt_data;
`else
    logic w_unused_src_addr;

    assign w_unused_src_addr = ^{rs_addr, rt_addr};
    assign w_op_a            = rs_data;
    assign w_rt_val          = rt_data;
`endif

    assign w_op_b = alu_src ? imm : w_rt_val;
    assign w_slt  = $signed(w_op_a) < $signed(w_op_b);

    // ALU; unknown codes produce zero, add/sub wrap silently.
    always_comb begin
        w_alu_result = '0;
        case (ALU_control)
            OP_ADD:  w_alu_result = w_op_a + w_op_b;
            OP_SUB:  w_alu_result = w_op_a - w_op_b;
            OP_AND:  w_alu_result = w_op_a & w_op_b;
            OP_OR:   w_alu_result = w_op_a | w_op_b;
            OP_SLT:  w_alu_result = DATA_W'(w_slt);
            default: w_alu_result = '0;
        endcase
    end

    assign w_zero = (w_alu_result == '0);

    // EX/MEM register: flush beats stall beats load; an empty slot loads a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_alu_result <= '0;
            r_zero       <= 1'b0;
            r_store_data <= '0;
            r_rd_addr    <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else if (flush || (!stall && !in_valid)) begin
            r_valid      <= 1'b0;
            r_alu_result <= '0;
            r_zero       <= 1'b0;
            r_store_data <= '0;
            r_rd_addr    <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else if (!stall) begin
            r_valid      <= 1'b1;
            r_alu_result <= w_alu_result;
            r_zero       <= w_zero;
            r_store_data <= w_rt_val;
            r_rd_addr    <= rd_addr;
            r_reg_write  <= reg_write;
            r_mem_read   <= mem_read;
            r_mem_write  <= mem_write;
        end
    end

    assign ex_valid      = r_valid;
    assign ex_alu_result = r_alu_result;
    assign ex_zero       = r_zero;
    assign ex_store_data = r_store_data;
    assign ex_rd_addr    = r_rd_addr;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vectors plus randomized traffic
// against a behavioural model of the EX/MEM register.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, stall, flush, alu_src;
    logic [2:0]  ALU_control;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic        reg_write, mem_read, mem_write;

    logic        ex_valid, ex_zero, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_rd_addr;

    logic        m_valid, m_zero, m_rw, m_mr, m_mw;
    logic [31:0] m_res, m_store;
    logic [4:0]  m_rd;

    int total = 0;
    int bad   = 0;

`ifdef EX_STAGE_FORWARD_EN
    localparam logic [31:0] FWD_EXP = 32'd11;
`else
    localparam logic [31:0] FWD_EXP = 32'd1;
`endif

    ex_stage #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .ALU_control(ALU_control), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .alu_src(alu_src), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_zero(ex_zero),
        .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b111:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_clear();
        m_valid = 0; m_zero = 0; m_rw = 0; m_mr = 0; m_mw = 0;
        m_res = 0; m_store = 0; m_rd = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 32'(ex_valid), 32'(m_valid));
        check({tag, ".res"},   ex_alu_result, m_res);
        check({tag, ".zero"},  32'(ex_zero), 32'(m_zero));
        check({tag, ".store"}, ex_store_data, m_store);
        check({tag, ".rd"},    32'(ex_rd_addr), 32'(m_rd));
        check({tag, ".rw"},    32'(ex_reg_write), 32'(m_rw));
        check({tag, ".mr"},    32'(ex_mem_read), 32'(m_mr));
        check({tag, ".mw"},    32'(ex_mem_write), 32'(m_mw));
        check({tag, ".ctl_inv"}, 32'(!ex_valid && (ex_reg_write || ex_mem_read || ex_mem_write)), 32'd0);
    endtask

    // Apply the current inputs for one edge, advance the model, and compare.
    task automatic clock_step(input string tag);
        logic        fwd_ok, keep, load;
        logic [31:0] a, rtv, b, r;
        fwd_ok = 1'b0;
`ifdef EX_STAGE_FORWARD_EN
        fwd_ok = m_valid && m_rw && !m_mr && (m_rd != 5'd0);
`endif
        a    = (fwd_ok && m_rd == rs_addr) ? m_res : rs_data;
        rtv  = (fwd_ok && m_rd == rt_addr) ? m_res : rt_data;
        b    = alu_src ? imm : rtv;
        r    = ref_alu(ALU_control, a, b);
        keep = !flush && stall;
        load = !flush && !stall && in_valid;
        @(posedge clk);
        #1;
        if (load) begin
            m_valid = 1; m_res = r; m_zero = (r == 0); m_store = rtv; m_rd = rd_addr;
            m_rw = reg_write; m_mr = mem_read; m_mw = mem_write;
        end else if (!keep) begin
            model_clear();
        end
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                             input logic [31:0] im, input logic src, input logic [4:0] rsa,
                             input logic [4:0] rta, input logic [4:0] rda,
                             input logic rw, input logic mr, input logic mw);
        in_valid = 1; stall = 0; flush = 0;
        ALU_control = op; rs_data = rs; rt_data = rt; imm = im; alu_src = src;
        rs_addr = rsa; rt_addr = rta; rd_addr = rda;
        reg_write = rw; mem_read = mr; mem_write = mw;
    endtask

    initial begin
        rst_n = 0;
        set_instr(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        in_valid = 0;
        model_clear();
        #7;
        check_all("reset");
        @(negedge clk);
        rst_n = 1;

        // ALU operations with rs=all-ones, rt=1
        set_instr(3'b010, 32'hFFFF_FFFF, 1, 0, 0, 1, 2, 3, 1, 0, 0);
        clock_step("add");
        check("add_lit", ex_alu_result, 32'h0);
        check("add_zero_lit", 32'(ex_zero), 32'd1);
        ALU_control = 3'b110; clock_step("sub");
        check("sub_lit", ex_alu_result, 32'hFFFF_FFFE);
        ALU_control = 3'b000; clock_step("and");
        check("and_lit", ex_alu_result, 32'h1);
        ALU_control = 3'b001; clock_step("or");
        check("or_lit", ex_alu_result, 32'hFFFF_FFFF);
        ALU_control = 3'b111; clock_step("slt");
        check("slt_lit", ex_alu_result, 32'h1);
        ALU_control = 3'b011; clock_step("bad_op");
        check("bad_op_lit", ex_alu_result, 32'h0);
        check("bad_op_zero_lit", 32'(ex_zero), 32'd1);

        // Immediate operand with store data taken from rt
        set_instr(3'b010, 5, 32'h1234, 32'hFFFF_FFFD, 1, 1, 2, 0, 0, 0, 1);
        clock_step("imm");
        check("imm_res_lit", ex_alu_result, 32'd2);
        check("imm_store_lit", ex_store_data, 32'h1234);
        check("imm_mw_lit", 32'(ex_mem_write), 32'd1);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        model_clear();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1;

        // Stall holds, flush overrides stall
        set_instr(3'b010, 3, 4, 0, 0, 1, 2, 9, 1, 0, 0);
        clock_step("load7");
        set_instr(3'b110, 100, 1, 0, 0, 1, 2, 10, 1, 1, 1);
        stall = 1;
        clock_step("stall1");
        clock_step("stall2");
        check("stall_lit", ex_alu_result, 32'd7);
        flush = 1;
        clock_step("stall_flush");
        check("flush_valid_lit", 32'(ex_valid), 32'd0);
        check("flush_res_lit", ex_alu_result, 32'd0);

        // Empty slot loads a bubble
        set_instr(3'b010, 3, 4, 0, 0, 1, 2, 9, 1, 0, 1);
        clock_step("pre_bubble");
        in_valid = 0;
        clock_step("bubble");

        // EX-to-EX forwarding and its rd=0 exclusion
        set_instr(3'b010, 4, 6, 0, 0, 1, 2, 8, 1, 0, 0);
        clock_step("fwd_src");
        set_instr(3'b010, 0, 0, 1, 1, 8, 3, 4, 1, 0, 0);
        clock_step("fwd_use");
        check("fwd_lit", ex_alu_result, FWD_EXP);
        set_instr(3'b010, 4, 6, 0, 0, 1, 2, 0, 1, 0, 0);
        clock_step("fwd0_src");
        set_instr(3'b010, 0, 0, 1, 1, 0, 3, 4, 1, 0, 0);
        clock_step("fwd0_use");
        check("fwd0_lit", ex_alu_result, 32'd1);

        // A load in EX/MEM is never forwarded
        set_instr(3'b010, 4, 6, 0, 0, 1, 2, 8, 1, 1, 0);
        clock_step("ld_src");
        set_instr(3'b010, 3, 0, 1, 1, 8, 3, 4, 1, 0, 0);
        clock_step("ld_use");
        check("ld_lit", ex_alu_result, 32'd4);

        // Reset during stall+flush, then stall holds the cleared state
        stall = 1; flush = 1;
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        model_clear();
        check_all("rst_in_stall");
        @(negedge clk);
        rst_n = 1; flush = 0;
        clock_step("post_rst_stall");
        stall = 0;
        clock_step("post_rst_load");

        // Randomized traffic, small register range to exercise forwarding
        for (int i = 0; i < 400; i++) begin
            in_valid    = ($urandom_range(0, 9) < 8);
            stall       = ($urandom_range(0, 9) < 2);
            flush       = ($urandom_range(0, 19) == 0);
            ALU_control = 3'($urandom);
            rs_data     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
            rt_data     = ($urandom_range(0, 3) == 0) ? rs_data : $urandom;
            imm         = $urandom;
            alu_src     = 1'($urandom);
            rs_addr     = 5'($urandom_range(0, 3));
            rt_addr     = 5'($urandom_range(0, 3));
            rd_addr     = 5'($urandom_range(0, 3));
            reg_write   = 1'($urandom);
            mem_read    = ($urandom_range(0, 3) == 0);
            mem_write   = 1'($urandom);
            clock_step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
